// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the RV32 instruction fetch sequencer.
package fetch_seq_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        STALL = 3'd2,
        DROP  = 3'd3,
        TRAP  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_seq_skid.sv
// Single-entry holding buffer for an instruction word and its PC.
module fetch_seq_skid #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [31:0]     load_inst,
    input  logic [XLEN-1:0] load_pc,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    output logic            valid
);

    // Clear wins over load so a redirect can never leave a stale entry behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            inst  <= 32'h0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= load_inst;
            pc    <= load_pc;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: owns the PC, drives the I-cache handshake and
// presents registered instructions to decode with redirect and stall handling.
module fetch_seq #(
    parameter int unsigned XLEN = fetch_seq_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(fetch_seq_pkg::RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    input  logic            dmem_stall,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     inst,
    output logic            inst_valid,
    output logic            flush,
    output logic            misalign
);

    import fetch_seq_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pend_target;
    logic            pend_valid;

    logic            redir_take_c;
    logic            skid_load_c;
    logic            skid_unload_c;
    logic            skid_clear_c;
    logic [31:0]     skid_inst;
    logic [XLEN-1:0] skid_pc;
    logic            skid_valid;

    assign imem_addr = fetch_pc;

    // Skid controls mirror the FSM decisions below; TRAP ignores redirects.
    always_comb begin
        redir_take_c  = redir_valid && (state != TRAP);
        skid_clear_c  = rst || redir_take_c;
        skid_load_c   = (state == FETCH) && imem_ready && dmem_stall;
        skid_unload_c = (state == STALL) && !dmem_stall;
    end

    fetch_seq_skid #(
        .XLEN (XLEN)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load_c),
        .unload    (skid_unload_c),
        .clear     (skid_clear_c),
        .load_inst (imem_rdata),
        .load_pc   (fetch_pc),
        .inst      (skid_inst),
        .pc        (skid_pc),
        .valid     (skid_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            pend_target <= RESET_PC;
            pend_valid  <= 1'b0;
            imem_req    <= 1'b0;
            inst        <= 32'h0;
            pc          <= RESET_PC;
            inst_valid  <= 1'b0;
            flush       <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            flush <= 1'b0;
            if (redir_take_c) begin
                flush      <= 1'b1;
                inst_valid <= 1'b0;
                inst       <= NOP_INST;
                if (redir_target[1:0] != 2'b00) begin
                    // Misaligned target: never request it, park until reset.
                    state      <= TRAP;
                    imem_req   <= 1'b0;
                    misalign   <= 1'b1;
                    pend_valid <= 1'b0;
                end else begin
                    case (state)
                        FETCH: begin
                            if (imem_ready) begin
                                fetch_pc <= redir_target;
                            end else begin
                                pend_target <= redir_target;
                                pend_valid  <= 1'b1;
                                state       <= DROP;
                            end
                        end
                        DROP: begin
                            if (imem_ready) begin
                                fetch_pc   <= redir_target;
                                pend_valid <= 1'b0;
                                state      <= FETCH;
                            end else begin
                                pend_target <= redir_target;
                            end
                        end
                        default: begin
                            fetch_pc <= redir_target;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    endcase
                end
            end else begin
                case (state)
                    IDLE: begin
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end
                    FETCH: begin
                        if (imem_ready && !dmem_stall) begin
                            inst       <= imem_rdata;
                            pc         <= fetch_pc;
                            inst_valid <= 1'b1;
                            fetch_pc   <= fetch_pc + XLEN'(4);
                        end else if (imem_ready) begin
                            fetch_pc <= fetch_pc + XLEN'(4);
                            imem_req <= 1'b0;
                            state    <= STALL;
                        end else if (!dmem_stall) begin
                            inst_valid <= 1'b0;
                            inst       <= NOP_INST;
                        end
                    end
                    STALL: begin
                        if (!dmem_stall) begin
                            inst       <= skid_inst;
                            pc         <= skid_pc;
                            inst_valid <= skid_valid;
                            imem_req   <= 1'b1;
                            state      <= FETCH;
                        end
                    end
                    DROP: begin
                        // Old address stays on the bus until its response is swallowed.
                        inst_valid <= 1'b0;
                        if (imem_ready && pend_valid) begin
                            fetch_pc   <= pend_target;
                            pend_valid <= 1'b0;
                            state      <= FETCH;
                        end
                    end
                    default: begin
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b0;
                        misalign   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: reset, streaming, stall/skid, drop, redirects, trap, wrap.
module tb_fetch_seq;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        flush;
    logic        misalign;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_seq u_dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .dmem_stall   (dmem_stall),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .pc           (pc),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .flush        (flush),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    // Memory returns an address-derived word so each fetch is distinguishable.
    assign imem_rdata = word_of(imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        imem_ready   = 1'b1;
        dmem_stall   = 1'b0;
        redir_valid  = 1'b0;
        redir_target = 32'h0;

        // Reset state
        step();
        chk("rst_req",      32'(imem_req),   32'd0);
        chk("rst_valid",    32'(inst_valid), 32'd0);
        chk("rst_inst",     inst,            32'h0);
        chk("rst_pc",       pc,              32'h0);
        chk("rst_flush",    32'(flush),      32'd0);
        chk("rst_misalign", 32'(misalign),   32'd0);

        // Streaming after reset: one IDLE bubble, then addresses 0,4,8,C
        rst = 1'b0;
        step();
        chk("boot_req",   32'(imem_req),   32'd1);
        chk("boot_addr0", imem_addr,       32'h0);
        chk("boot_valid", 32'(inst_valid), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("stream_addr",  imem_addr,       32'(4 * i));
            chk("stream_valid", 32'(inst_valid), 32'd1);
            chk("stream_pc",    pc,              32'(4 * (i - 1)));
            chk("stream_inst",  inst,            word_of(32'(4 * (i - 1))));
        end
        step();
        chk("pre_stall_pc",   pc,   32'h10);
        chk("pre_stall_inst", inst, word_of(32'h10));

        // Stall for 3 cycles with ready high: 0x14 goes to skid
        dmem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_req",   32'(imem_req),   32'd0);
            chk("stall_inst",  inst,            word_of(32'h10));
            chk("stall_pc",    pc,              32'h10);
            chk("stall_valid", 32'(inst_valid), 32'd1);
        end
        chk("skid_held", u_dut.skid_inst, word_of(32'h14));
        dmem_stall = 1'b0;
        step();
        chk("unstall_pc",    pc,              32'h14);
        chk("unstall_inst",  inst,            word_of(32'h14));
        chk("unstall_valid", 32'(inst_valid), 32'd1);
        chk("unstall_req",   32'(imem_req),   32'd1);
        chk("unstall_addr",  imem_addr,       32'h18);

        // Advance to 0x20, then withhold ready and redirect to 0x100
        step();
        step();
        chk("at_0x20", imem_addr, 32'h20);
        imem_ready   = 1'b0;
        redir_valid  = 1'b1;
        redir_target = 32'h100;
        step();
        chk("drop_flush", 32'(flush),      32'd1);
        chk("drop_addr",  imem_addr,       32'h20);
        chk("drop_req",   32'(imem_req),   32'd1);
        chk("drop_valid", 32'(inst_valid), 32'd0);
        redir_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drop_hold_addr",  imem_addr,       32'h20);
            chk("drop_hold_flush", 32'(flush),      32'd0);
            chk("drop_hold_valid", 32'(inst_valid), 32'd0);
        end
        imem_ready = 1'b1;
        step();
        chk("drop_exit_addr",  imem_addr,       32'h100);
        chk("drop_exit_valid", 32'(inst_valid), 32'd0);
        step();
        chk("tgt_pc",   pc,   32'h100);
        chk("tgt_inst", inst, word_of(32'h100));

        // Two redirects while dropping: newest target wins
        imem_ready   = 1'b0;
        redir_valid  = 1'b1;
        redir_target = 32'h200;
        step();
        chk("dbl_flush1", 32'(flush), 32'd1);
        redir_target = 32'h300;
        step();
        chk("dbl_flush2", 32'(flush), 32'd1);
        chk("dbl_addr",   imem_addr,  32'h104);
        redir_valid = 1'b0;
        imem_ready  = 1'b1;
        step();
        chk("dbl_flush_off", 32'(flush), 32'd0);
        chk("dbl_next_addr", imem_addr,  32'h300);
        step();
        chk("dbl_pc", pc, 32'h300);

        // Redirect with ready in FETCH to the top word, then wrap to 0
        redir_valid  = 1'b1;
        redir_target = 32'hFFFF_FFFC;
        step();
        chk("wrap_flush", 32'(flush),      32'd1);
        chk("wrap_valid", 32'(inst_valid), 32'd0);
        chk("wrap_addr",  imem_addr,       32'hFFFF_FFFC);
        redir_valid = 1'b0;
        step();
        chk("wrap_next", imem_addr, 32'h0);
        chk("wrap_pc",   pc,        32'hFFFF_FFFC);

        // Misaligned redirect traps until reset
        redir_valid  = 1'b1;
        redir_target = 32'h102;
        step();
        chk("trap_misalign", 32'(misalign),   32'd1);
        chk("trap_flush",    32'(flush),      32'd1);
        chk("trap_req",      32'(imem_req),   32'd0);
        chk("trap_valid",    32'(inst_valid), 32'd0);
        redir_target = 32'h400;
        step();
        redir_valid = 1'b0;
        step();
        chk("trap_sticky",    32'(misalign),   32'd1);
        chk("trap_req_hold",  32'(imem_req),   32'd0);
        chk("trap_flush_off", 32'(flush),      32'd0);
        chk("trap_val_hold",  32'(inst_valid), 32'd0);
        rst = 1'b1;
        step();
        chk("trap_rst_mis", 32'(misalign), 32'd0);
        chk("trap_rst_req", 32'(imem_req), 32'd0);
        rst = 1'b0;
        step();
        chk("restart_addr", imem_addr,     32'h0);
        chk("restart_req",  32'(imem_req), 32'd1);
        step();
        chk("restart_inst", inst, word_of(32'h0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
